dlt_seq_checker: RTL and testbench
==================================

Name: dlt_seq_checker

Overview:
- Stimulus sequencer and golden-model checker for the 32-output CC_DLT latch parameter sweep array.
- Drives the array's d/g/sr inputs through a glitch-safe Gray sequence, samples its 32-bit q bus after a settle window, and compares it against an internal latch model.
- Reports sticky per-bit errors, a mismatch count and pass/fail.

Parameters:
- SETTLE_CYCLES, 2, wait cycles between driving stimulus and sampling q (>=1).
- NUM_STEPS, 64, number of stimulus steps per run (>=4).
- ERR_CNT_W, 8, width of the saturating mismatch-step counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse to begin a run; ignored while busy.
- d  out  1  latch data to the array (registered).
- g  out  1  latch gate to the array (registered).
- sr  out  1  sr to the array (registered; the array's SR pins are tied constant, so sr is driven only for coverage).
- q  in  32  array outputs; bit k = 2*i + j, with i = parameter index 0..15 and j = constant-SR value 0..1.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start or rst.
- pass  out  1  valid when done: 1 iff err_mask == 0.
- err_mask  out  32  sticky OR of per-bit mismatches.
- err_count  out  ERR_CNT_W  count of steps with any mismatch; saturates at all-ones.

Behaviour:
- Reset: rst clears all outputs to 0 (d, g, sr, busy, done, pass, err_mask, err_count), clears step, returns FSM to IDLE, and clears the model.
  - A mid-run reset takes effect on the next edge with no further compares.
- Per-instance parameters for bit k: G_INV = i[0], SR_INV = i[1], SR_VAL = i[2], INIT = i[3], SR pin = j.
- Stimulus for step n: gray = n[1:0] ^ (n[1:0] >> 1); g = gray[1], d = gray[0], sr = n[2].
  - Exactly one of d/g changes per step, including the wrap from step 3 to step 4.
- FSM states and transitions:
  - IDLE: on start, clear err_mask and err_count, set step = 0, go to DRIVE.
  - DRIVE (1 cycle): register the stimulus for step onto d/g/sr and update the model. Go to SETTLE.
  - SETTLE: stay SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE (1 cycle): compare q against the model on known bits.
    - mis = (q ^ model) & known.
    - err_mask |= mis.
    - If mis != 0, err_count increments (saturating).
  - NEXT (1 cycle): step++. If step == NUM_STEPS-1 before the increment, go to DONE; otherwise go to DRIVE.
  - DONE: done = 1, pass = (err_mask == 0), busy = 0. start returns to IDLE-equivalent restart (clear and begin) on the same edge.
- busy = 1 in every state from DRIVE through NEXT.
- Run length is NUM_STEPS*(SETTLE_CYCLES+3) cycles from the start edge to done = 1. With defaults this is 320.
- Model update in DRIVE, per bit:
  - SR active (j ^ SR_INV) = 1: model = SR_VAL, known = 1.
  - Else if (g ^ G_INV) = 1 (transparent): model = d, known = 1.
  - Else: hold model and known.
- Known mask after reset or start (without the optional feature): only SR-active bits set; their model = SR_VAL.
- A start pulse while busy is ignored. A start that coincides with rst is dropped.

Optional Feature:
- Macro: DLT_SEQ_CHECK_INIT_EN.
- Defined: reset/start loads known = all-ones and model = INIT for every non-SR-active bit, so hold states before the first transparent phase are checked. Valid only when rst coincides with device configuration.
- Undefined: those bits stay unknown (unchecked) until first written.

Test Plan:
- Ideal latch behavioural model on q, default params, start pulse -> done = 1 at cycle 320, pass = 1, err_mask = 0, err_count = 0.
- q[0] stuck at 1 (i=0, j=0), otherwise ideal -> err_mask = 32'h0000_0001, err_count = 46 (48 with DLT_SEQ_CHECK_INIT_EN), pass = 0.
- q[4] stuck at 1 (i=2, j=0, SR-active, SR_VAL=0) -> err_mask = 32'h0000_0010, err_count = 64.
- Check d/g/sr across steps 0..4 -> (g,d) = 00, 01, 11, 10, 00 and sr = 0, 0, 0, 0, 1. Exactly one of d/g toggles per DRIVE.
- rst asserted at step 10 during SETTLE -> next cycle all outputs 0 and FSM IDLE. A new start completes a full 320-cycle run.
- ERR_CNT_W = 4 with all q bits inverted -> err_count saturates at 15. start asserted while busy has no effect on the step count.

Source files
------------

// File: rtl/dlt_seq_checker.sv
// -----------------------------------------------------------------------------
// dlt_seq_checker
//
// Stimulus sequencer and golden-model checker for the 32-output CC_DLT latch
// parameter sweep array. Each run walks NUM_STEPS stimulus steps. For every
// step it drives d/g/sr with a Gray sequence, waits SETTLE_CYCLES, samples q
// and compares it against an internal ideal-latch model. Mismatches are
// accumulated as a sticky per-bit mask and a saturating count of failing steps.
//
// Optional build macro: DLT_SEQ_CHECK_INIT_EN
//   defined   : reset/start marks every bit known. Non-SR-active bits start at
//               their INIT value, so hold phases before the first transparent
//               phase are also checked. Only meaningful when rst coincides
//               with device configuration.
//   undefined : only SR-active bits are known after reset/start. The other
//               bits become known the first time they go transparent.
//
// Ports:
//   clk        in   single clock
//   rst        in   synchronous, active-high reset
//   start      in   pulse to begin a run (ignored while busy, dropped under rst)
//   d, g, sr   out  registered stimulus to the array (sr is coverage only; the
//                   array's SR pins are tied constant)
//   q          in   32-bit array outputs, bit k = 2*i + j
//   busy       out  run in progress (DRIVE..NEXT)
//   done       out  run complete, held until next start or rst
//   pass       out  valid with done: 1 iff err_mask == 0
//   err_mask   out  sticky OR of per-bit mismatches
//   err_count  out  saturating count of steps with any mismatch
// -----------------------------------------------------------------------------
module dlt_seq_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_STEPS     = 64,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 d,
  output logic                 g,
  output logic                 sr,
  input  logic [31:0]          q,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          err_mask,
  output logic [ERR_CNT_W-1:0] err_count
);

  // The step counter must always expose bit 2, which drives sr.
  localparam int STEP_W = ($clog2(NUM_STEPS) < 3) ? 3 : $clog2(NUM_STEPS);
  localparam int CNT_W  = ($clog2(SETTLE_CYCLES) < 1) ? 1 : $clog2(SETTLE_CYCLES);

  // Per-bit parameter masks. Bit k decodes as j = k[0] and i = k[4:1]:
  //   G_INV = i[0] = k[1], SR_INV = i[1] = k[2], SR_VAL = i[2] = k[3],
  //   INIT = i[3] = k[4]. The SR pin is j, so SR is active when k[0] ^ k[2].
  function automatic logic [31:0] f_param_mask(input logic [2:0] sel);
    logic [31:0] m;
    logic [4:0]  kb;
    m = 32'h0000_0000;
    for (int k = 0; k < 32; k++) begin
      kb = 5'(k);
      case (sel)
        3'd0:    m[k] = kb[0] ^ kb[2];
        3'd1:    m[k] = kb[3];
        3'd2:    m[k] = kb[1];
        3'd3:    m[k] = kb[4];
        default: m[k] = 1'b0;
      endcase
    end
    return m;
  endfunction

  localparam logic [31:0] SR_ACT_MASK = f_param_mask(3'd0);
  localparam logic [31:0] SR_VAL_MASK = f_param_mask(3'd1);
  localparam logic [31:0] G_INV_MASK  = f_param_mask(3'd2);

`ifdef DLT_SEQ_CHECK_INIT_EN
  localparam logic [31:0] INIT_MASK  = f_param_mask(3'd3);
  localparam logic [31:0] KNOWN_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] MODEL_RST  = (SR_ACT_MASK & SR_VAL_MASK) | (~SR_ACT_MASK & INIT_MASK);
`else
  localparam logic [31:0] KNOWN_RST  = SR_ACT_MASK;
  localparam logic [31:0] MODEL_RST  = SR_ACT_MASK & SR_VAL_MASK;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   d_q, d_d;
  logic                   g_q, g_d;
  logic                   sr_q, sr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [31:0]            err_mask_q, err_mask_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [31:0]            model_q, model_d;
  logic [31:0]            known_q, known_d;

  logic                   g_s, d_s, sr_s;
  logic [31:0]            transp_s;
  logic [31:0]            model_upd_s;
  logic [31:0]            known_upd_s;
  logic [31:0]            mis_s;

  // Stimulus for the current step and the model state it would produce.
  // gray = n[1:0] ^ (n[1:0] >> 1), so g = n[1] and d = n[0] ^ n[1]; only one
  // of them changes per step, including the 3 -> 4 wrap.
  always_comb begin
    g_s         = step_q[1];
    d_s         = step_q[0] ^ step_q[1];
    sr_s        = step_q[2];
    transp_s    = {32{g_s}} ^ G_INV_MASK;
    model_upd_s = (SR_ACT_MASK & SR_VAL_MASK)
                | (~SR_ACT_MASK & transp_s & {32{d_s}})
                | (~SR_ACT_MASK & ~transp_s & model_q);
    known_upd_s = SR_ACT_MASK | transp_s | known_q;
  end

  // Next-state and registered-output logic of the run sequencer.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    g_d         = g_q;
    sr_d        = sr_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    model_d     = model_q;
    known_d     = known_q;
    mis_s       = 32'h0000_0000;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Start from DONE restarts exactly like start from IDLE.
        if (start) begin
          state_d     = ST_DRIVE;
          step_d      = '0;
          err_mask_d  = 32'h0000_0000;
          err_count_d = '0;
          model_d     = MODEL_RST;
          known_d     = KNOWN_RST;
        end else begin
          state_d     = state_q;
        end
      end
      ST_DRIVE: begin
        d_d     = d_s;
        g_d     = g_s;
        sr_d    = sr_s;
        model_d = model_upd_s;
        known_d = known_upd_s;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        mis_s      = (q ^ model_q) & known_q;
        err_mask_d = err_mask_q | mis_s;
        if ((mis_s != 32'h0000_0000) && (err_count_q != {ERR_CNT_W{1'b1}})) begin
          err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
          err_count_d = err_count_q;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          state_d = ST_DONE;
        end else begin
          step_d  = step_q + STEP_W'(1);
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered off the next state so they line up with it.
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) ||
             (state_d == ST_SAMPLE) || (state_d == ST_NEXT);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_mask_d == 32'h0000_0000);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      d_q         <= 1'b0;
      g_q         <= 1'b0;
      sr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_mask_q  <= 32'h0000_0000;
      err_count_q <= '0;
      model_q     <= MODEL_RST;
      known_q     <= KNOWN_RST;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      g_q         <= g_d;
      sr_q        <= sr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      model_q     <= model_d;
      known_q     <= known_d;
    end
  end

  assign d         = d_q;
  assign g         = g_q;
  assign sr        = sr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dlt_seq_checker.sv
module tb_dlt_seq_checker;

`ifdef DLT_SEQ_CHECK_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam int SETTLE  = 2;
  localparam int STEPS   = 64;
  localparam int RUN_CYC = STEPS * (SETTLE + 3);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        cfg_req = 1'b0;

  logic        d, g, sr, busy, done, pass;
  logic [31:0] err_mask;
  logic [7:0]  err_count;
  logic        d2, g2, sr2, busy2, done2, pass2;
  logic [31:0] err_mask2;
  logic [3:0]  err_count2;

  logic [31:0] arr1, arr2, q1, q2;
  logic [31:0] f_s1 = 32'h0, f_s0 = 32'h0, f_inv = 32'h0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dlt_seq_checker dut (
    .clk(clk), .rst(rst), .start(start), .d(d), .g(g), .sr(sr), .q(q1),
    .busy(busy), .done(done), .pass(pass), .err_mask(err_mask), .err_count(err_count)
  );

  dlt_seq_checker #(.ERR_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .d(d2), .g(g2), .sr(sr2), .q(q2),
    .busy(busy2), .done(done2), .pass(pass2), .err_mask(err_mask2), .err_count(err_count2)
  );

  // Instance parameters of the latch array, straight from i = k/2, j = k%2.
  function automatic bit p_ginv(int k);  return bit'((k / 2) % 2); endfunction
  function automatic bit p_sract(int k); return bit'((k % 2) ^ (((k / 2) / 2) % 2)); endfunction
  function automatic bit p_srval(int k); return bit'(((k / 2) / 4) % 2); endfunction
  function automatic bit p_init(int k);  return bit'(((k / 2) / 8) % 2); endfunction

  function automatic bit latch_next(int k, bit cur, int dv, int gv);
    if (p_sract(k)) return p_srval(k);
    else if ((gv ^ int'(p_ginv(k))) != 0) return bit'(dv);
    else return cur;
  endfunction

  // Ideal latch array, reacting a few time units after each clock edge.
  always @(posedge clk) begin
    #3;
    for (int k = 0; k < 32; k++) begin
      arr1[k] <= cfg_req ? p_init(k) : latch_next(k, arr1[k], int'(d), int'(g));
      arr2[k] <= cfg_req ? p_init(k) : latch_next(k, arr2[k], int'(d2), int'(g2));
    end
  end

  assign q1 = ((arr1 ^ f_inv) | f_s1) & ~f_s0;
  assign q2 = ~arr2;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected result of a whole run, stepping through the rules step by step.
  task automatic ref_model(input logic [31:0] s1, input logic [31:0] s0, input logic [31:0] inv,
                           input int w, output logic [31:0] emask, output int ecnt);
    bit arr[32];
    bit mdl[32];
    bit kn[32];
    bit obs, any;
    int gv, dv, ph;
    emask = 32'h0;
    ecnt  = 0;
    for (int k = 0; k < 32; k++) begin
      arr[k] = p_init(k);
      kn[k]  = p_sract(k) || INIT_EN;
      mdl[k] = p_sract(k) ? p_srval(k) : (INIT_EN ? p_init(k) : 1'b0);
    end
    for (int n = 0; n < STEPS; n++) begin
      ph  = n % 4;
      gv  = (ph >= 2) ? 1 : 0;
      dv  = (ph == 1 || ph == 2) ? 1 : 0;
      any = 1'b0;
      for (int k = 0; k < 32; k++) begin
        arr[k] = latch_next(k, arr[k], dv, gv);
        if (p_sract(k) || ((gv ^ int'(p_ginv(k))) != 0)) begin
          mdl[k] = latch_next(k, mdl[k], dv, gv);
          kn[k]  = 1'b1;
        end
        obs = ((arr[k] ^ inv[k]) | s1[k]) & ~s0[k];
        if (kn[k] && obs != mdl[k]) begin
          emask[k] = 1'b1;
          any      = 1'b1;
        end
      end
      if (any && ecnt < (1 << w) - 1) ecnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cfg_req = 1'b1; start = 1'b0; start2 = 1'b0;
    @(negedge clk);
    rst = 1'b0; cfg_req = 1'b0;
  endtask

  task automatic cfg_array();
    @(negedge clk); cfg_req = 1'b1;
    @(negedge clk); cfg_req = 1'b0;
  endtask

  // Pulse start on dut, wait for done, return cycles from the start edge.
  task automatic run_and_wait(output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy_done", {busy, done}, 2'b10);
    cyc = 0;
    while (!done && cyc < 2 * RUN_CYC) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s0;
    logic [31:0] inv;
    logic [31:0] emask;
    int          ecnt;
    bit          epass;
  } vec_t;

  vec_t vecs[7];
  int   exp_gd[5] = '{0, 1, 3, 2, 0};
  int   exp_sr[5] = '{0, 0, 0, 0, 1};

  initial begin
    int cyc, cyc1, s, ecnt;
    logic [1:0] prev;
    logic [31:0] emask;
    bit pulse;

    vecs[0] = '{32'h0,  32'h0,  32'h0, 32'h0,  0, 1'b1};
    vecs[1] = '{32'h1,  32'h0,  32'h0, 32'h1,  INIT_EN ? 48 : 46, 1'b0};
    vecs[2] = '{32'h10, 32'h0,  32'h0, 32'h10, 64, 1'b0};
    vecs[3] = '{32'h0,  32'h2,  32'h0, 32'h0,  0, 1'b1};
    vecs[4] = '{32'h0,  32'h20, 32'h0, 32'h20, 16, 1'b0};
    vecs[5] = '{32'h5,  32'h0,  32'h0, 32'h5,  INIT_EN ? 48 : 47, 1'b0};
    vecs[6] = '{32'h0,  32'h0,  32'h8, 32'h8,  64, 1'b0};

    // Reset state
    do_reset();
    chk("reset_outs", {d, g, sr, busy, done, pass, err_mask, err_count}, 0);
    chk("reset_outs_sat", {d2, g2, sr2, busy2, done2, pass2, err_mask2, err_count2}, 0);

    // Fault table
    for (int v = 0; v < 7; v++) begin
      do_reset();
      f_s1 = vecs[v].s1; f_s0 = vecs[v].s0; f_inv = vecs[v].inv;
      run_and_wait(cyc);
      chk($sformatf("vec%0d_cycles", v), cyc, RUN_CYC);
      chk($sformatf("vec%0d_err_mask", v), err_mask, vecs[v].emask);
      chk($sformatf("vec%0d_err_count", v), err_count, vecs[v].ecnt);
      chk($sformatf("vec%0d_pass", v), pass, vecs[v].epass);
    end

    // Stimulus sequence over steps 0..4
    do_reset();
    f_s1 = 32'h0; f_s0 = 32'h0; f_inv = 32'h0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prev = 2'b00;
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk); #1;
      if ((e - 1) % (SETTLE + 3) == 0) begin
        s = (e - 1) / (SETTLE + 3);
        chk($sformatf("stim%0d_gd", s), {g, d}, exp_gd[s]);
        chk($sformatf("stim%0d_sr", s), sr, exp_sr[s]);
        if (s > 0) chk($sformatf("stim%0d_one_toggle", s), $countones({g, d} ^ prev), 1);
        prev = {g, d};
      end
    end
    cyc = 21;
    while (!done && cyc < 2 * RUN_CYC) begin
      @(posedge clk); #1; cyc++;
    end
    chk("stim_run_cycles", cyc, RUN_CYC);
    chk("stim_run_pass", pass, 1);

    // Mid-run reset during step 10 SETTLE
    do_reset();
    f_s1 = 32'h1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int e = 1; e <= 52; e++) begin
      @(posedge clk); #1;
    end
    chk("mid_busy_gd", {busy, g, d}, 3'b111);
    chk("mid_err_count", err_count, INIT_EN ? 8 : 6);
    @(negedge clk); rst = 1'b1; cfg_req = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_outs", {d, g, sr, busy, done, pass, err_mask, err_count}, 0);
    @(negedge clk); rst = 1'b0; cfg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_reset_idle", {busy, done}, 2'b00);
    run_and_wait(cyc);
    chk("post_reset_cycles", cyc, RUN_CYC);
    chk("post_reset_err_count", err_count, INIT_EN ? 48 : 46);
    chk("post_reset_err_mask", err_mask, 32'h1);

    // start coinciding with rst is dropped
    @(negedge clk); rst = 1'b1; start = 1'b1; cfg_req = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0; cfg_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("start_with_rst_dropped", {busy, done}, 2'b00);

    // start pulses while busy; saturating counter on the 4-bit instance
    do_reset();
    f_s1 = 32'h0;
    ref_model(32'h0, 32'h0, 32'hFFFF_FFFF, 4, emask, ecnt);
    @(negedge clk); start = 1'b1; start2 = 1'b1;
    @(negedge clk); start = 1'b0; start2 = 1'b0;
    cyc = 0; cyc1 = 0;
    while (!done2 && cyc < 2 * RUN_CYC) begin
      @(posedge clk); #1; cyc++;
      if (done && cyc1 == 0) cyc1 = cyc;
      pulse = (cyc == 100) || ((cyc < RUN_CYC - 5) && ($urandom_range(0, 7) == 0));
      start = pulse; start2 = pulse;
    end
    start = 1'b0; start2 = 1'b0;
    chk("busy_start_cycles_sat", cyc, RUN_CYC);
    chk("busy_start_cycles", cyc1, RUN_CYC);
    chk("sat_err_count", err_count2, 15);
    chk("sat_err_count_model", err_count2, ecnt);
    chk("sat_err_mask", err_mask2, emask);
    chk("sat_flags", {pass2, busy2, sr2}, 3'b001);
    chk("ideal_after_busy_starts", {pass, err_mask, err_count}, {1'b1, 40'h0});

    // Restart straight from DONE
    cfg_array();
    f_s1 = 32'h1;
    run_and_wait(cyc);
    chk("restart_cycles", cyc, RUN_CYC);
    chk("restart_err_count", err_count, INIT_EN ? 48 : 46);
    chk("restart_pass", pass, 0);

    // Random fault patterns against the reference model
    for (int r = 0; r < 6; r++) begin
      f_s1  = $urandom & $urandom & $urandom;
      f_s0  = $urandom & $urandom & $urandom & ~f_s1;
      f_inv = $urandom & $urandom & $urandom;
      ref_model(f_s1, f_s0, f_inv, 8, emask, ecnt);
      do_reset();
      run_and_wait(cyc);
      chk($sformatf("rnd%0d_cycles", r), cyc, RUN_CYC);
      chk($sformatf("rnd%0d_err_mask", r), err_mask, emask);
      chk($sformatf("rnd%0d_err_count", r), err_count, ecnt);
      chk($sformatf("rnd%0d_pass", r), pass, (emask == 32'h0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
